pooled_feature_collector: RTL and testbench
===========================================

# pooled_feature_collector

Collects the per-channel results of the global average pooling stage into an on-chip vector of `NUM_CH` fixed-point features. It then streams that vector to the downstream classifier / linear layer over a valid/ready handshake. It sits directly after the pooling stage, sampling that stage's `done` strobe and result word. An optional tracker reports the index and value of the largest pooled feature.

## Interface
- `IL`, 4: integer bits of the signed fixed-point word.
- `FL`, 16: fractional bits; word width W = IL+FL.
- `NUM_CH`, 64: channels per frame (vector length), ≥2.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `en`  in  1  global enable; when 0 all state holds and no capture occurs.
- `start`  in  1  one-cycle pulse that begins a new frame.
- `done_in`  in  1  pooling-stage done strobe.
- `data_in`  in  W  pooling-stage result word, signed.
- `out_data`  out  W  feature word to downstream, signed.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts.
- `out_last`  out  1  qualifies the final feature (index NUM_CH-1).
- `busy`  out  1  high in COLLECT or DRAIN.
- `err`  out  1  sticky overrun flag, cleared by `start`.
- `max_idx`  out  clog2(NUM_CH)  argmax channel (ARGMAX_EN only).
- `max_val`  out  W  max feature value (ARGMAX_EN only).

## Operation
- States: IDLE, COLLECT, DRAIN.
- IDLE: `start` → COLLECT. The same edge clears the write pointer, the read pointer, `err` and the argmax.
- COLLECT, capture: `done_in` is registered into `cap_pend`. The pooling stage updates its result one cycle after asserting done, so `data_in` is written to `buf[wr_ptr]` on the cycle `cap_pend`=1.
- COLLECT, advance: each write increments `wr_ptr`. The write at `wr_ptr`=NUM_CH-1 moves the FSM to DRAIN on the next edge.
- COLLECT, repeated strobes: a `done_in` held high for consecutive cycles counts as one capture per cycle. The upstream guarantees single-cycle strobes.
- DRAIN: `out_valid`=1 and `out_data`=`buf[rd_ptr]`. A transfer occurs when `out_valid` & `out_ready`, and each transfer increments `rd_ptr`. The transfer with `out_last`=1 moves the FSM to IDLE.
- DRAIN, overrun: `done_in` during DRAIN sets `err`, and the data is discarded.
- `start` outside IDLE: restarts the frame. All pointers clear, the state becomes COLLECT, and buffered data is abandoned. `err` clears.
- Arithmetic: values are stored unmodified with no saturation. Comparisons are signed W-bit.
- `en`=0: freezes all registers, including `cap_pend`. A pending capture completes once `en` returns to 1.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `err`=0, `max_idx`=0, `max_val`=most-negative W-bit value, state=IDLE.
- Capture latency: `done_in` at cycle t → data sampled at t+1 → written at the t+1 edge.
- Drain start: after the last write, `out_valid` rises on the following cycle.
- Outputs are registered. `out_data`/`out_last` change only after a transfer and stay stable while `out_valid` & !`out_ready`.
- Back-to-back: a full-rate drain takes NUM_CH cycles with `out_ready` held at 1.
- Simultaneous `start` and `done_in`: `start` wins. That `done_in` is ignored, and no `cap_pend` is set from it.

## Configuration
- `PFC_ARGMAX_EN` defined: on each write, if `data_in` > `max_val` (strict, signed), update `max_val` and `max_idx`. Ties keep the lower index. The values are valid from the cycle the FSM enters DRAIN until the next `start`.
- `PFC_ARGMAX_EN` undefined: `max_idx`/`max_val` ports and logic are removed.

## Structure
- Package `pfc_pkg`:
  - state enum `pfc_state_t` {IDLE, COLLECT, DRAIN};
  - function for the most-negative W-bit constant.
- Sub-module `pfc_vec_ram`: NUM_CH×W single-write, single-async-read register array, with no reset on the data.

## Test plan
- Reset mid-DRAIN (`rstn` low at rd_ptr=10) → all outputs at reset values immediately. Then `start` + 64 captures → full drain of the new data.
- Basic frame, NUM_CH=4: `start`, then `done_in` with data 0x00100, 0x00200, 0xFFF00, 0x00050 → drains the same four words in order, `out_last` on the 4th, FSM returns to IDLE.
- Backpressure: `out_ready` toggled 1,0,0,1,… during drain → no word lost or duplicated, and `out_data` stable while stalled.
- Overrun: `done_in` during DRAIN → `err`=1 and the drained data is unchanged. The next `start` clears `err`.
- Restart: `start` after 2 of 4 captures → the first two values are never output, and the next 4 captures drain.
- Argmax (`PFC_ARGMAX_EN`): data {-3.0, 1.5, 1.5, 0.25} → `max_idx`=1 and `max_val`=1.5 (0x18000) at DRAIN.

Source files
------------

// File: rtl/pooled_feature_collector_pkg.sv
// Shared types and constants for the pooled feature collector.
// The PFC_ARGMAX_EN build option is handled in the top module.
package pfc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } pfc_state_t;

    // Only bit w-1 is set; the caller truncates the result to w bits.
    function automatic logic [63:0] pfc_most_neg(input int unsigned w);
        logic [63:0] r;
        r        = '0;
        r[w-1]   = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pooled_feature_collector_vec_ram.sv
// Feature vector storage: one synchronous write port and one asynchronous read port.
// The data array has no reset.
module pfc_vec_ram #(
    parameter int W      = 20,
    parameter int NUM_CH = 64,
    localparam int AW    = $clog2(NUM_CH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [NUM_CH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pooled_feature_collector.sv
// Captures NUM_CH pooled channel results into a vector, then streams the vector out.
// Define PFC_ARGMAX_EN to add the max_idx/max_val tracker.
module pooled_feature_collector
    import pfc_pkg::*;
#(
    parameter int IL      = 4,
    parameter int FL      = 16,
    parameter int NUM_CH  = 64,
    localparam int W      = IL + FL,
    localparam int AW     = $clog2(NUM_CH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          start,
    input  logic          done_in,
    input  logic [W-1:0]  data_in,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          err
`ifdef PFC_ARGMAX_EN
    ,
    output logic [AW-1:0] max_idx,
    output logic [W-1:0]  max_val
`endif
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CH - 1);
    localparam logic [W-1:0]  MOST_NEG = W'(pfc_most_neg(W));

    pfc_state_t    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          cap_pend_q, cap_pend_d;
    logic          err_q, err_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  out_data_q, out_data_d;

    logic          mem_we;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;

    // Read port looks one entry ahead so out_data can be registered on each transfer.
    always_comb begin
        rd_addr = '0;
        if (state_q == ST_DRAIN && rd_ptr_q != LAST_IDX) begin
            rd_addr = rd_ptr_q + AW'(1);
        end
    end

    pfc_vec_ram #(
        .W      (W),
        .NUM_CH (NUM_CH)
    ) u_vec_ram (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cap_pend_d  = cap_pend_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        mem_we      = 1'b0;

        if (en) begin
            if (start) begin
                state_d     = ST_COLLECT;
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                cap_pend_d  = 1'b0;
                err_d       = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                out_data_d  = '0;
            end else begin
                case (state_q)
                    ST_COLLECT: begin
                        cap_pend_d = done_in;
                        if (cap_pend_q) begin
                            mem_we = 1'b1;
                            if (wr_ptr_q == LAST_IDX) begin
                                // A strobe alongside the final write has no slot left.
                                state_d     = ST_DRAIN;
                                wr_ptr_d    = '0;
                                rd_ptr_d    = '0;
                                cap_pend_d  = 1'b0;
                                err_d       = err_q | done_in;
                                out_valid_d = 1'b1;
                                out_last_d  = 1'b0;
                                out_data_d  = rd_data;
                            end else begin
                                wr_ptr_d = wr_ptr_q + AW'(1);
                            end
                        end
                    end
                    ST_DRAIN: begin
                        cap_pend_d = 1'b0;
                        if (done_in) begin
                            err_d = 1'b1;
                        end
                        if (out_ready) begin
                            if (out_last_q) begin
                                state_d     = ST_IDLE;
                                out_valid_d = 1'b0;
                                out_last_d  = 1'b0;
                            end else begin
                                rd_ptr_d   = rd_ptr_q + AW'(1);
                                out_data_d = rd_data;
                                out_last_d = (rd_ptr_q + AW'(1)) == LAST_IDX;
                            end
                        end
                    end
                    default: begin
                        cap_pend_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cap_pend_q  <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cap_pend_q  <= cap_pend_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef PFC_ARGMAX_EN
    logic [AW-1:0] max_idx_q, max_idx_d;
    logic [W-1:0]  max_val_q, max_val_d;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        max_idx_d = max_idx_q;
        max_val_d = max_val_q;
        if (en) begin
            if (start) begin
                max_idx_d = '0;
                max_val_d = MOST_NEG;
            end else if (mem_we && ($signed(data_in) > $signed(max_val_q))) begin
                max_idx_d = wr_ptr_q;
                max_val_d = data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            max_idx_q <= '0;
            max_val_q <= MOST_NEG;
        end else begin
            max_idx_q <= max_idx_d;
            max_val_q <= max_val_d;
        end
    end

    assign max_idx = max_idx_q;
    assign max_val = max_val_q;
`endif

endmodule

// File: tb/tb_pooled_feature_collector.sv
// Directed bench for pooled_feature_collector: a NUM_CH=4 instance for frame-level cases
// and a NUM_CH=64 instance for reset-during-drain and a full-length drain.
module tb_pooled_feature_collector;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         en = 1'b1;
    logic         done_in = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         out_ready = 1'b0;
    logic         start4 = 1'b0;
    logic         start64 = 1'b0;

    logic [W-1:0] o4_data, o64_data;
    logic         o4_valid, o4_last, o4_busy, o4_err;
    logic         o64_valid, o64_last, o64_busy, o64_err;
`ifdef PFC_ARGMAX_EN
    logic [1:0]   mi4;
    logic [5:0]   mi64;
    logic [W-1:0] mv4, mv64;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pooled_feature_collector #(.IL(4), .FL(16), .NUM_CH(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .en(en), .start(start4), .done_in(done_in), .data_in(data_in),
        .out_data(o4_data), .out_valid(o4_valid), .out_ready(out_ready), .out_last(o4_last),
        .busy(o4_busy), .err(o4_err)
`ifdef PFC_ARGMAX_EN
        , .max_idx(mi4), .max_val(mv4)
`endif
    );

    pooled_feature_collector #(.IL(4), .FL(16), .NUM_CH(64)) u_dut64 (
        .clk(clk), .rstn(rstn), .en(en), .start(start64), .done_in(done_in), .data_in(data_in),
        .out_data(o64_data), .out_valid(o64_valid), .out_ready(out_ready), .out_last(o64_last),
        .busy(o64_busy), .err(o64_err)
`ifdef PFC_ARGMAX_EN
        , .max_idx(mi64), .max_val(mv64)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // done_in pulse, then the result word on the following cycle.
    task automatic cap(input logic [W-1:0] v);
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        data_in = v;
    endtask

    task automatic pulse_start4();
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic pulse_start64();
        @(negedge clk);
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
    endtask

    // Drain the 4-entry instance; bp selects the 1,0,0,1 ready pattern.
    task automatic drain4(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input logic [W-1:0] e2, input logic [W-1:0] e3, input bit bp);
        logic [W-1:0] exp_q [4];
        logic         pat [4];
        logic         r;
        int           idx;
        int           cyc;
        exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 60) begin
            @(negedge clk);
            r = bp ? pat[cyc % 4] : 1'b1;
            check({tag, "_valid"}, {31'b0, o4_valid}, 32'd1);
            check({tag, "_data"}, {12'b0, o4_data}, {12'b0, exp_q[idx]});
            check({tag, "_last"}, {31'b0, o4_last}, (idx == 3) ? 32'd1 : 32'd0);
            out_ready = r;
            if (r) idx++;
            cyc++;
        end
        check({tag, "_count"}, idx, 32'd4);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_end"}, {31'b0, o4_valid}, 32'd0);
        check({tag, "_busy_end"}, {31'b0, o4_busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst4_valid", {31'b0, o4_valid}, 32'd0);
        check("rst4_last",  {31'b0, o4_last},  32'd0);
        check("rst4_data",  {12'b0, o4_data},  32'd0);
        check("rst4_busy",  {31'b0, o4_busy},  32'd0);
        check("rst4_err",   {31'b0, o4_err},   32'd0);
`ifdef PFC_ARGMAX_EN
        check("rst4_maxidx", {30'b0, mi4}, 32'd0);
        check("rst4_maxval", {12'b0, mv4}, 32'h80000);
`endif
        rstn = 1'b1;

        // 64-channel frame, reset asserted after 10 transfers
        pulse_start64();
        check("c64_busy", {31'b0, o64_busy}, 32'd1);
        for (int i = 0; i < 64; i++) cap(W'(i * 7 + 3));
        @(negedge clk);
        check("c64_valid", {31'b0, o64_valid}, 32'd1);
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        check("c64_mid_data", {12'b0, o64_data}, 32'd73);
        rstn = 1'b0;
        #1;
        check("c64_rst_valid", {31'b0, o64_valid}, 32'd0);
        check("c64_rst_data",  {12'b0, o64_data},  32'd0);
        check("c64_rst_last",  {31'b0, o64_last},  32'd0);
        check("c64_rst_busy",  {31'b0, o64_busy},  32'd0);
        check("c64_rst_err",   {31'b0, o64_err},   32'd0);
        @(negedge clk);
        rstn = 1'b1;
        pulse_start64();
        for (int i = 0; i < 64; i++) cap(W'(32'hF0000 + i * 5));
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            check("d64_valid", {31'b0, o64_valid}, 32'd1);
            check("d64_data", {12'b0, o64_data}, 32'hF0000 + 32'(i * 5));
            check("d64_last", {31'b0, o64_last}, (i == 63) ? 32'd1 : 32'd0);
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("d64_valid_end", {31'b0, o64_valid}, 32'd0);
        check("d64_busy_end",  {31'b0, o64_busy},  32'd0);

        // basic frame, full-rate drain
        pulse_start4();
        cap(20'h00100); cap(20'h00200); cap(20'hFFF00); cap(20'h00050);
        drain4("basic", 20'h00100, 20'h00200, 20'hFFF00, 20'h00050, 1'b0);

        // backpressure
        pulse_start4();
        cap(20'h12345); cap(20'h0ABCD); cap(20'h80001); cap(20'h7FFFF);
        drain4("bp", 20'h12345, 20'h0ABCD, 20'h80001, 20'h7FFFF, 1'b1);

        // overrun during drain
        pulse_start4();
        cap(20'h00011); cap(20'h00022); cap(20'h00033); cap(20'h00044);
        @(negedge clk);
        check("ovr_err_before", {31'b0, o4_err}, 32'd0);
        done_in = 1'b1;
        data_in = 20'hDEAD0;
        @(negedge clk);
        done_in = 1'b0;
        check("ovr_err_set", {31'b0, o4_err}, 32'd1);
        drain4("ovr", 20'h00011, 20'h00022, 20'h00033, 20'h00044, 1'b0);
        check("ovr_err_sticky", {31'b0, o4_err}, 32'd1);
        pulse_start4();
        check("ovr_err_clear", {31'b0, o4_err}, 32'd0);

        // restart after two captures; the restart coincides with a done_in strobe
        cap(20'h0AAAA); cap(20'h0BBBB);
        @(negedge clk);
        start4 = 1'b1;
        done_in = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        done_in = 1'b0;
        data_in = 20'h0EEEE;
        cap(20'h00001); cap(20'h00002); cap(20'h00003); cap(20'h00004);
        drain4("rst", 20'h00001, 20'h00002, 20'h00003, 20'h00004, 1'b0);

        // enable low while a capture is pending
        pulse_start4();
        cap(20'h00101);
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        en = 1'b0;
        data_in = 20'h0F0F0;
        repeat (3) @(negedge clk);
        check("en_busy_hold", {31'b0, o4_busy}, 32'd1);
        en = 1'b1;
        data_in = 20'h00202;
        cap(20'h00303); cap(20'h00404);
        drain4("en", 20'h00101, 20'h00202, 20'h00303, 20'h00404, 1'b0);

`ifdef PFC_ARGMAX_EN
        pulse_start4();
        check("am_clr_val", {12'b0, mv4}, 32'h80000);
        cap(20'hD0000); cap(20'h18000); cap(20'h18000); cap(20'h04000);
        @(negedge clk);
        check("am_idx", {30'b0, mi4}, 32'd1);
        check("am_val", {12'b0, mv4}, 32'h18000);
        drain4("am", 20'hD0000, 20'h18000, 20'h18000, 20'h04000, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
